sparc_decode_issue: RTL and testbench
=====================================

// Module: sparc_decode_issue
// PURPOSE
//  Decode/issue stage directly upstream of the register file. Accepts fetched SPARC V8
//  instructions over a valid/ready handshake and holds one instruction in a decode register.
//  Drives that instruction's rs1/rs2 to the register file read ports.
//  Decodes formats 1/2/3 into an issue bundle for execute, and stalls on RAW hazards
//  using a 32-entry busy scoreboard cleared by writeback.
// PARAMETERS
//  REG_BITS_SIZE  5   register address width
//  NO_OF_REG      32  scoreboard entries (= 2**REG_BITS_SIZE)
//  INST_SIZE      32  instruction/PC/immediate width
// PORTS
//  clk           in   1   clock
//  reset         in   1   reset, synchronous, active-high
//  if_valid      in   1   fetch offers if_inst/if_pc
//  if_ready      out  1   decode register can accept this cycle
//  if_inst       in   32  instruction word
//  if_pc         in   32  instruction address
//  flush         in   1   discard decode-register contents (branch redirect)
//  rf_rs1        out  5   register file read address 1
//  rf_rs2        out  5   register file read address 2
//  id_valid      out  1   issue bundle valid (decode full and no hazard)
//  id_ready      in   1   execute accepts bundle
//  id_pc         out  32  PC of issued instruction
//  id_op         out  2   inst[31:30]
//  id_op3        out  6   inst[24:19] for op=1x, {3'b0,op2} for op=00, 0 for CALL
//  id_rd         out  5   destination (15 for CALL)
//  id_use_imm    out  1   second operand is id_imm, not rs2 value
//  id_imm        out  32  formatted immediate (see BEHAVIOUR)
//  id_writes_rd  out  1   instruction writes id_rd (never when id_rd==0)
//  wb_valid      in   1   writeback retires a result this cycle
//  wb_rd         in   5   writeback destination
//  id_illegal    out  1   only with SPARC_ILLEGAL_CHECK_EN
// BEHAVIOUR
//  - Reset: decode register empty, all busy bits 0, id_valid=0, if_ready=1; all id_* and rf_* outputs 0.
//  - Decode register D: load when if_valid&&if_ready. if_ready = !D.valid || issue.
//    issue = id_valid&&id_ready. Back-to-back issue sustains 1 instr/cycle.
//  - Combinational outputs: rf_rs1/rf_rs2/id_* are decoded from D, not registered again.
//    rf_rs1=inst[18:14], rf_rs2=inst[4:0] when D holds format 3, else 0.
//    The register file samples them on the falling edge, so execute sees operand values at the issuing posedge.
//  - Decode: op=01 CALL: rd=15, writes, imm=sext(disp30)<<2.
//    op=00, op2=100 SETHI: imm={imm22,10'b0}, writes unless rd==0.
//    op=00, op2=010 Bicc: imm=sext(disp22)<<2, no write.
//    op=10 ALU: use_imm=inst[13], imm=sext(simm13), writes unless rd==0.
//    op=11 memory: loads (op3[2]==0) write rd; stores (op3[2]==1) don't write.
//  - Sources for hazard: format 3 -> rs1, plus rs2 if i==0, plus rd if store. Others: none.
//    Register 0 never hazards.
//  - Hazard: any source has busy bit set -> id_valid=0, D held, if_ready=0.
//    Busy bits are registered, so a wb clearing a bit lets issue proceed next cycle (no bypass).
//  - Scoreboard: on issue with id_writes_rd set busy[id_rd]. On wb_valid clear busy[wb_rd].
//    Same reg same cycle: set wins. wb to a non-busy reg: no effect. busy[0] constant 0.
//  - flush: D.valid<=0 next cycle; a same-cycle if_valid is dropped (if_ready forced 0).
//    No issue that cycle (id_valid masked). Scoreboard untouched, since in-flight writes still retire.
//  - reset mid-stall clears everything; in-flight writebacks after reset are ignored.
// CONFIGURATION
//  SPARC_ILLEGAL_CHECK_EN defined:
//   - id_illegal=1 for op=00 op2 not in {010,100}, and for op=10/11 op3 outside the implemented table in sparc_pkg.
//   - An illegal instruction issues with id_writes_rd=0 and sets no busy bit.
//  Not defined: port absent; unknown encodings decode per the op rules above.
// STRUCTURE
//  sparc_pkg: op_e (CALL/BR_SETHI/ALU/MEM), op2/op3 localparams, decode_t struct
//   (pc, op, op3, rd, use_imm, imm, writes_rd, src mask), implemented-op3 table.
//  Sub-module sparc_scoreboard: busy vector, set/clear ports, 3 read ports returning busy.
// TESTING
//  - Reset, then ADD r3,r1,r2 (0x86004002), id_ready=1 -> next cycle id_valid=1, rf_rs1=1, rf_rs2=2,
//    id_rd=3, writes=1; busy[3]=1 after issue.
//  - Then SUB r4,r3,5 -> held, id_valid=0, if_ready=0 until wb_valid wb_rd=3; issues cycle after wb.
//  - SETHI 0x12345,r5 -> id_imm=0x048D1400. CALL disp30=-1 -> id_imm=0xFFFFFFFC, id_rd=15.
//    BA disp22=4 -> imm=16, no write.
//  - id_ready=0 for 3 cycles with D full -> if_ready=0, D stable; release -> single issue, no duplicate.
//  - flush with if_valid=1 while D full -> next cycle id_valid=0, offered instr dropped; busy bits unchanged.
//  - wb_valid wb_rd=7 same cycle as issue writing r7 -> busy[7]=1. OR r0 write -> busy[0] stays 0.

Source files
------------

// File: rtl/sparc_pkg.sv
// Shared decode types, opcode constants and the SPARC V8 field decoder for the
// decode/issue stage.
package sparc_pkg;

  localparam int REG_BITS_SIZE = 5;
  localparam int NO_OF_REG     = 32;
  localparam int INST_SIZE     = 32;

  typedef enum logic [1:0] {
    OP_BR_SETHI = 2'b00,
    OP_CALL     = 2'b01,
    OP_ALU      = 2'b10,
    OP_MEM      = 2'b11
  } op_e;

  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  localparam logic [5:0] OP3_ADD   = 6'b000000;
  localparam logic [5:0] OP3_AND   = 6'b000001;
  localparam logic [5:0] OP3_OR    = 6'b000010;
  localparam logic [5:0] OP3_XOR   = 6'b000011;
  localparam logic [5:0] OP3_SUB   = 6'b000100;
  localparam logic [5:0] OP3_ANDN  = 6'b000101;
  localparam logic [5:0] OP3_ORN   = 6'b000110;
  localparam logic [5:0] OP3_XNOR  = 6'b000111;
  localparam logic [5:0] OP3_ADDCC = 6'b010000;
  localparam logic [5:0] OP3_SUBCC = 6'b010100;
  localparam logic [5:0] OP3_SLL   = 6'b100101;
  localparam logic [5:0] OP3_SRL   = 6'b100110;
  localparam logic [5:0] OP3_SRA   = 6'b100111;
  localparam logic [5:0] OP3_JMPL  = 6'b111000;

  localparam logic [5:0] OP3_LD    = 6'b000000;
  localparam logic [5:0] OP3_LDUB  = 6'b000001;
  localparam logic [5:0] OP3_LDUH  = 6'b000010;
  localparam logic [5:0] OP3_ST    = 6'b000100;
  localparam logic [5:0] OP3_STB   = 6'b000101;
  localparam logic [5:0] OP3_STH   = 6'b000110;

  localparam logic [REG_BITS_SIZE-1:0] CALL_RD = 5'd15;

  localparam int SRC_RS1 = 0;
  localparam int SRC_RS2 = 1;
  localparam int SRC_RD  = 2;

  typedef struct packed {
    logic [INST_SIZE-1:0]     pc;
    op_e                      op;
    logic [5:0]               op3;
    logic [REG_BITS_SIZE-1:0] rd;
    logic                     use_imm;
    logic [INST_SIZE-1:0]     imm;
    logic                     writes_rd;
    logic [2:0]               src;
    logic                     illegal;
  } decode_t;

  function automatic logic op3_implemented(input op_e op, input logic [5:0] op3);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_ALU: begin
        case (op3)
          OP3_ADD, OP3_AND, OP3_OR, OP3_XOR, OP3_SUB, OP3_ANDN, OP3_ORN,
          OP3_XNOR, OP3_ADDCC, OP3_SUBCC, OP3_SLL, OP3_SRL, OP3_SRA,
          OP3_JMPL: hit = 1'b1;
          default:  hit = 1'b0;
        endcase
      end
      OP_MEM: begin
        case (op3)
          OP3_LD, OP3_LDUB, OP3_LDUH, OP3_ST, OP3_STB, OP3_STH: hit = 1'b1;
          default: hit = 1'b0;
        endcase
      end
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic decode_t decode_inst(input logic [INST_SIZE-1:0] inst,
                                          input logic [INST_SIZE-1:0] pc);
    decode_t d;
    d         = '0;
    d.pc      = pc;
    d.op      = op_e'(inst[31:30]);
    d.rd      = inst[29:25];
    case (d.op)
      OP_CALL: begin
        d.rd        = CALL_RD;
        d.writes_rd = 1'b1;
        d.imm       = {inst[29:0], 2'b00};
      end
      OP_BR_SETHI: begin
        d.op3 = {3'b000, inst[24:22]};
        case (inst[24:22])
          OP2_SETHI: begin
            d.imm       = {inst[21:0], 10'b0000000000};
            d.writes_rd = (inst[29:25] != 5'd0);
          end
          OP2_BICC: d.imm     = {{8{inst[21]}}, inst[21:0], 2'b00};
          default:  d.illegal = 1'b1;
        endcase
      end
      OP_ALU, OP_MEM: begin
        d.op3          = inst[24:19];
        d.use_imm      = inst[13];
        d.imm          = {{19{inst[12]}}, inst[12:0]};
        d.src[SRC_RS1] = 1'b1;
        d.src[SRC_RS2] = ~inst[13];
        d.illegal      = ~op3_implemented(d.op, inst[24:19]);
        // Memory op3[2] distinguishes stores, whose rd is a data source.
        if (d.op == OP_MEM) begin
          d.src[SRC_RD] = inst[21];
          d.writes_rd   = ~inst[21] && (inst[29:25] != 5'd0);
        end else begin
          d.writes_rd   = (inst[29:25] != 5'd0);
        end
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sparc_scoreboard.sv
// Register busy scoreboard: one bit per architectural register, set on issue,
// cleared on writeback, with three combinational read ports.
module sparc_scoreboard
  import sparc_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [REG_BITS_SIZE-1:0] set_addr,
  input  logic                     clr_en,
  input  logic [REG_BITS_SIZE-1:0] clr_addr,
  input  logic [REG_BITS_SIZE-1:0] rd_addr_a,
  input  logic [REG_BITS_SIZE-1:0] rd_addr_b,
  input  logic [REG_BITS_SIZE-1:0] rd_addr_c,
  output logic                     busy_a,
  output logic                     busy_b,
  output logic                     busy_c
);

  logic [NO_OF_REG-1:0] busy_r;
  logic [NO_OF_REG-1:0] busy_nxt_s;

  // Next busy vector: clear first so a same-register set takes priority; r0 never busy.
  always_comb begin
    busy_nxt_s = busy_r;
    if (clr_en) begin
      busy_nxt_s[clr_addr] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (set_en) begin
      busy_nxt_s[set_addr] = 1'b1;
    end else begin
      busy_nxt_s[set_addr] = busy_nxt_s[set_addr];
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Busy register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy_a = busy_r[rd_addr_a];
  assign busy_b = busy_r[rd_addr_b];
  assign busy_c = busy_r[rd_addr_c];

endmodule

// File: rtl/sparc_decode_issue.sv
// Decode/issue stage: one-entry decode register, field decode, RAW hazard stall.
// Optional illegal-encoding detection under macro SPARC_ILLEGAL_CHECK_EN.
module sparc_decode_issue
  import sparc_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [INST_SIZE-1:0]     if_inst,
  input  logic [INST_SIZE-1:0]     if_pc,
  input  logic                     flush,
  output logic [REG_BITS_SIZE-1:0] rf_rs1,
  output logic [REG_BITS_SIZE-1:0] rf_rs2,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [INST_SIZE-1:0]     id_pc,
  output logic [1:0]               id_op,
  output logic [5:0]               id_op3,
  output logic [REG_BITS_SIZE-1:0] id_rd,
  output logic                     id_use_imm,
  output logic [INST_SIZE-1:0]     id_imm,
  output logic                     id_writes_rd,
`ifdef SPARC_ILLEGAL_CHECK_EN
  output logic                     id_illegal,
`endif
  input  logic                     wb_valid,
  input  logic [REG_BITS_SIZE-1:0] wb_rd
);

  logic                 d_valid_r;
  logic [INST_SIZE-1:0] d_inst_r;
  logic [INST_SIZE-1:0] d_pc_r;
  decode_t              dec_s;
  logic                 writes_s;
  logic                 hazard_s;
  logic                 issue_s;
  logic                 busy_rs1_s;
  logic                 busy_rs2_s;
  logic                 busy_rd_s;

  assign dec_s = decode_inst(d_inst_r, d_pc_r);

`ifdef SPARC_ILLEGAL_CHECK_EN
  assign writes_s   = dec_s.writes_rd && !dec_s.illegal;
  assign id_illegal = d_valid_r && dec_s.illegal;
`else
  assign writes_s   = dec_s.writes_rd;
`endif

  assign hazard_s = (dec_s.src[SRC_RS1] && busy_rs1_s) ||
                    (dec_s.src[SRC_RS2] && busy_rs2_s) ||
                    (dec_s.src[SRC_RD]  && busy_rd_s);
  assign issue_s  = id_valid && id_ready;

  // Issue bundle and register-file addresses, forced to zero while the decode register is empty.
  always_comb begin
    id_valid = d_valid_r && !hazard_s && !flush;
    if_ready = !flush && (!d_valid_r || issue_s);
    if (d_valid_r) begin
      rf_rs1       = dec_s.op[1] ? d_inst_r[18:14] : 5'd0;
      rf_rs2       = dec_s.op[1] ? d_inst_r[4:0]   : 5'd0;
      id_pc        = dec_s.pc;
      id_op        = dec_s.op;
      id_op3       = dec_s.op3;
      id_rd        = dec_s.rd;
      id_use_imm   = dec_s.use_imm;
      id_imm       = dec_s.imm;
      id_writes_rd = writes_s;
    end else begin
      rf_rs1       = 5'd0;
      rf_rs2       = 5'd0;
      id_pc        = 32'd0;
      id_op        = 2'd0;
      id_op3       = 6'd0;
      id_rd        = 5'd0;
      id_use_imm   = 1'b0;
      id_imm       = 32'd0;
      id_writes_rd = 1'b0;
    end
  end

  // Decode register: flush empties it, otherwise load on accept or drain on issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_valid_r <= 1'b0;
      d_inst_r  <= 32'd0;
      d_pc_r    <= 32'd0;
    end else if (flush) begin
      d_valid_r <= 1'b0;
    end else if (if_valid && if_ready) begin
      d_valid_r <= 1'b1;
      d_inst_r  <= if_inst;
      d_pc_r    <= if_pc;
    end else if (issue_s) begin
      d_valid_r <= 1'b0;
    end
  end

  sparc_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_en    (issue_s && id_writes_rd),
    .set_addr  (id_rd),
    .clr_en    (wb_valid),
    .clr_addr  (wb_rd),
    .rd_addr_a (d_inst_r[18:14]),
    .rd_addr_b (d_inst_r[4:0]),
    .rd_addr_c (d_inst_r[29:25]),
    .busy_a    (busy_rs1_s),
    .busy_b    (busy_rs2_s),
    .busy_c    (busy_rd_s)
  );

endmodule

// File: tb/tb_sparc_decode_issue.sv
// Directed bench for sparc_decode_issue: decode vector table plus hazard,
// back-pressure, flush and scoreboard sequences.
module tb_sparc_decode_issue;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        flush;
  logic [4:0]  rf_rs1;
  logic [4:0]  rf_rs2;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [1:0]  id_op;
  logic [5:0]  id_op3;
  logic [4:0]  id_rd;
  logic        id_use_imm;
  logic [31:0] id_imm;
  logic        id_writes_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
`ifdef SPARC_ILLEGAL_CHECK_EN
  logic        id_illegal;
`endif

  int n_vec;
  int n_miss;
  int n_issue;

  sparc_decode_issue dut (
    .clk          (clk),
    .reset        (reset),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .flush        (flush),
    .rf_rs1       (rf_rs1),
    .rf_rs2       (rf_rs2),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_op        (id_op),
    .id_op3       (id_op3),
    .id_rd        (id_rd),
    .id_use_imm   (id_use_imm),
    .id_imm       (id_imm),
    .id_writes_rd (id_writes_rd),
`ifdef SPARC_ILLEGAL_CHECK_EN
    .id_illegal   (id_illegal),
`endif
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue counter, sampled mid-cycle when handshake inputs are stable.
  always @(negedge clk) begin
    if (!reset && id_valid && id_ready) n_issue <= n_issue + 1;
  end

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  op;
    logic [5:0]  op3;
    logic [4:0]  rd;
    logic        use_imm;
    logic [31:0] imm;
    logic        writes;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] ADD_R3 = 32'h86004002;
  localparam logic [31:0] SUB_R4 = 32'h8820E005;
  localparam logic [31:0] ADD_R5 = 32'h8A010002;  // add r5,r4,r2
  localparam logic [31:0] SETHI  = 32'h0B012345;
  localparam logic [31:0] CALLM1 = 32'h7FFFFFFF;
  localparam logic [31:0] OR_R6  = 32'h8C107FFF;
  localparam logic [31:0] OR_R0  = 32'h80104002;
  localparam logic [31:0] LD_R7  = 32'hCE00A008;

  initial begin
    n_vec = 0; n_miss = 0; n_issue = 0;
    reset = 1'b1; if_valid = 1'b0; if_inst = 32'd0; if_pc = 32'd0;
    flush = 1'b0; id_ready = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;

    vecs[0] = '{"add",   ADD_R3,       5'd1, 5'd2,  2'd2, 6'd0, 5'd3,  1'b0, 32'd2,        1'b1};
    vecs[1] = '{"sub",   SUB_R4,       5'd3, 5'd5,  2'd2, 6'd4, 5'd4,  1'b1, 32'd5,        1'b1};
    vecs[2] = '{"sethi", SETHI,        5'd0, 5'd0,  2'd0, 6'd4, 5'd5,  1'b0, 32'h048D1400, 1'b1};
    vecs[3] = '{"call",  CALLM1,       5'd0, 5'd0,  2'd1, 6'd0, 5'd15, 1'b0, 32'hFFFFFFFC, 1'b1};
    vecs[4] = '{"ba",    32'h10800004, 5'd0, 5'd0,  2'd0, 6'd2, 5'd8,  1'b0, 32'd16,       1'b0};
    vecs[5] = '{"bne",   32'h12BFFFFE, 5'd0, 5'd0,  2'd0, 6'd2, 5'd9,  1'b0, 32'hFFFFFFF8, 1'b0};
    vecs[6] = '{"or_m1", OR_R6,        5'd1, 5'd31, 2'd2, 6'd2, 5'd6,  1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[7] = '{"or_r0", OR_R0,        5'd1, 5'd2,  2'd2, 6'd2, 5'd0,  1'b0, 32'd2,        1'b0};
    vecs[8] = '{"ld",    LD_R7,        5'd2, 5'd8,  2'd3, 6'd0, 5'd7,  1'b1, 32'd8,        1'b1};
    vecs[9] = '{"st",    32'hD2204002, 5'd1, 5'd2,  2'd3, 6'd4, 5'd9,  1'b0, 32'd2,        1'b0};

    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_if_ready", if_ready, 1);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_rf_rs1", rf_rs1, 0);
    chk("rst_rf_rs2", rf_rs2, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_imm", id_imm, 0);
    chk("rst_id_rd", id_rd, 0);
    chk("rst_writes", id_writes_rd, 0);

    for (int i = 0; i < 10; i++) begin
      reset = 1'b1; tick(); reset = 1'b0;
      if_valid = 1'b1; if_inst = vecs[i].inst; if_pc = 32'h100 + 32'(4 * i); id_ready = 1'b0;
      tick();
      if_valid = 1'b0;
      #1;
      chk({vecs[i].name, "_valid"}, id_valid, 1);
      chk({vecs[i].name, "_rs1"}, rf_rs1, vecs[i].rs1);
      chk({vecs[i].name, "_rs2"}, rf_rs2, vecs[i].rs2);
      chk({vecs[i].name, "_op"}, id_op, vecs[i].op);
      chk({vecs[i].name, "_op3"}, id_op3, vecs[i].op3);
      chk({vecs[i].name, "_rd"}, id_rd, vecs[i].rd);
      chk({vecs[i].name, "_use_imm"}, id_use_imm, vecs[i].use_imm);
      chk({vecs[i].name, "_imm"}, id_imm, vecs[i].imm);
      chk({vecs[i].name, "_writes"}, id_writes_rd, vecs[i].writes);
      chk({vecs[i].name, "_pc"}, id_pc, 32'h100 + 32'(4 * i));
    end

    // RAW hazard: SUB r4,r3,5 waits for writeback of r3, issues the cycle after.
    reset = 1'b1; tick(); reset = 1'b0;
    if_valid = 1'b1; if_inst = ADD_R3; if_pc = 32'h200; id_ready = 1'b1;
    tick(); #1;
    chk("add_issue_valid", id_valid, 1);
    chk("add_if_ready", if_ready, 1);
    if_inst = SUB_R4; if_pc = 32'h204;
    tick();
    if_valid = 1'b0; #1;
    chk("busy3_set", dut.u_scoreboard.busy_r[3], 1);
    chk("haz_valid", id_valid, 0);
    chk("haz_if_ready", if_ready, 0);
    chk("haz_rs1", rf_rs1, 3);
    tick(); #1;
    chk("haz_hold_valid", id_valid, 0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd3; #1;
    chk("wb_no_bypass", id_valid, 0);
    tick();
    wb_valid = 1'b0; #1;
    chk("post_wb_valid", id_valid, 1);
    chk("post_wb_rd", id_rd, 4);
    chk("post_wb_pc", id_pc, 32'h204);
    tick(); #1;
    chk("sub_drained", id_valid, 0);
    chk("busy4_set", dut.u_scoreboard.busy_r[4], 1);
    chk("busy3_clr", dut.u_scoreboard.busy_r[3], 0);

    // Reset while stalled on r4 clears everything; a late writeback has no effect.
    if_valid = 1'b1; if_inst = ADD_R5; if_pc = 32'h208;
    tick();
    if_valid = 1'b0; #1;
    chk("r4_stall", id_valid, 0);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    chk("rst_mid_valid", id_valid, 0);
    chk("rst_mid_ready", if_ready, 1);
    chk("rst_mid_busy4", dut.u_scoreboard.busy_r[4], 0);
    chk("rst_mid_rs1", rf_rs1, 0);
    wb_valid = 1'b1; wb_rd = 5'd4;
    tick();
    wb_valid = 1'b0; #1;
    chk("late_wb_busy4", dut.u_scoreboard.busy_r[4], 0);

    // Back-pressure: D held for 3 cycles, then exactly one issue.
    id_ready = 1'b0;
    if_valid = 1'b1; if_inst = SETHI; if_pc = 32'h300;
    tick();
    if_inst = CALLM1; if_pc = 32'h304;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_if_ready", if_ready, 0);
      chk("bp_valid", id_valid, 1);
      chk("bp_pc", id_pc, 32'h300);
      chk("bp_imm", id_imm, 32'h048D1400);
      tick();
    end
    n_issue = 0;
    if_valid = 1'b0; id_ready = 1'b1; #1;
    chk("bp_release_ready", if_ready, 1);
    tick(); #1;
    chk("bp_after_valid", id_valid, 0);
    tick(); #1;
    chk("bp_no_dup", id_valid, 0);
    chk("bp_issue_count", n_issue, 1);
    chk("bp_busy5", dut.u_scoreboard.busy_r[5], 1);

    // Flush: offered instruction dropped, D emptied, scoreboard untouched.
    reset = 1'b1; tick(); reset = 1'b0;
    if_valid = 1'b1; if_inst = ADD_R3; if_pc = 32'h400; id_ready = 1'b1;
    tick();
    if_inst = OR_R6; if_pc = 32'h404;
    tick();
    id_ready = 1'b0; if_valid = 1'b0; #1;
    chk("fl_pre_valid", id_valid, 1);
    chk("fl_pre_pc", id_pc, 32'h404);
    flush = 1'b1; if_valid = 1'b1; if_inst = SUB_R4; if_pc = 32'h408; id_ready = 1'b1; #1;
    chk("fl_valid_mask", id_valid, 0);
    chk("fl_if_ready", if_ready, 0);
    tick();
    flush = 1'b0; if_valid = 1'b0; #1;
    chk("fl_after_valid", id_valid, 0);
    chk("fl_busy3_kept", dut.u_scoreboard.busy_r[3], 1);
    chk("fl_busy6_none", dut.u_scoreboard.busy_r[6], 0);
    tick(); #1;
    chk("fl_dropped", id_valid, 0);

    // Same-cycle set and clear of r7: set wins. Writes to r0 never mark busy.
    reset = 1'b1; tick(); reset = 1'b0;
    if_valid = 1'b1; if_inst = LD_R7; if_pc = 32'h500; id_ready = 1'b1;
    tick();
    if_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7; #1;
    chk("ld_valid", id_valid, 1);
    tick();
    wb_valid = 1'b0; #1;
    chk("set_wins_busy7", dut.u_scoreboard.busy_r[7], 1);
    if_valid = 1'b1; if_inst = OR_R0; if_pc = 32'h504;
    tick();
    if_valid = 1'b0;
    tick(); #1;
    chk("r0_busy", dut.u_scoreboard.busy_r[0], 0);
    chk("r0_drained", id_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
